serial_subtractor: RTL

Bit-serial two's-complement subtractor computing DIFF = A − B one bit per clock, LSB first, with a single registered borrow flip-flop. It is the subtract counterpart to the team's combinational full-adder datapath. It trades WIDTH+1 cycles of latency for one full-subtractor cell, a borrow register and shift registers. Upstream control hands it operands with a START pulse and collects the result on a one-cycle DONE pulse.

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first, one bit per clock

// One full-subtractor cell: difference and borrow-out for a single bit position.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// Bit-serial A - B using one fs_cell, a borrow flop, operand/result shift registers.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             OVF
);

  // Counter is sized one bit wider than strictly needed so WIDTH=2^n never wraps early.
  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic             bit_d;
  logic             br_next;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] res_next;

  fs_cell u_cell (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (br_next)
  );

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
  assign accept   = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign res_next = {bit_d, res_q[WIDTH-1:1]};

  // State register; reset wins over everything, including a pending START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: START is only honoured in IDLE or DONE, so it is ignored mid-operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (START) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = START ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Serial datapath: capture operands on accept, then shift one bit per SHIFT edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      opa_q <= A;
      opb_q <= B;
      res_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == ST_SHIFT) begin
      opa_q <= opa_q >> 1;
      opb_q <= opb_q >> 1;
      res_q <= res_next;
      br_q  <= br_next;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Result registers update only on the completion edge so partial sums never show.
  always_ff @(posedge CLK) begin
    if (RST) begin
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_bit) begin
      diff_q <= res_next;
      bout_q <= br_next;
      ovf_q  <= br_q ^ br_next;
    end
  end

  assign BUSY = (state_q == ST_SHIFT);
  assign DONE = (state_q == ST_DONE);
  assign DIFF = diff_q;
  assign BOUT = bout_q;
  assign OVF  = ovf_q;

endmodule
